// File: rtl/cpa_pipe.sv
// Pipelined carry-propagate adder: SEG-bit carry segment per stage, elastic valid/ready.
// Define CPA_PIPE_CIN_EN to add the cin port (sum = row_a + row_b + cin).
module cpa_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef CPA_PIPE_CIN_EN
  input  logic             cin,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] row_a,
  input  logic [WIDTH-1:0] row_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy
);

  localparam int NSTG = (WIDTH + SEG - 1) / SEG;

  logic [NSTG-1:0] v;
  logic [NSTG-1:0] adv;
  logic            cin0;

`ifdef CPA_PIPE_CIN_EN
  assign cin0 = cin;
`else
  assign cin0 = 1'b0;
`endif

  // Ready ripples back from the output; a stage may move if the next one frees up.
  always_comb begin
    adv = '0;
    for (int k = NSTG - 1; k >= 0; k--) begin
      if (k == NSTG - 1) adv[k] = v[k] & out_ready;
      else               adv[k] = v[k] & (!v[k+1] | adv[k+1]);
    end
  end

  assign in_ready  = !v[0] | adv[0];
  assign out_valid = v[NSTG-1];
  assign busy      = |v;

  for (genvar k = 0; k < NSTG; k++) begin : g_st
    localparam int LO = k * SEG;
    localparam int RW = WIDTH - LO;
    localparam int W  = (RW < SEG) ? RW : SEG;

    logic [RW-1:0]   a_src;
    logic [RW-1:0]   b_src;
    logic            c_src;
    logic            ld;
    logic [W:0]      seg;
    logic [LO+W-1:0] r_d;
    logic [LO+W-1:0] r_q;
    logic            c_q;
    logic            v_q;

    if (k == 0) begin : g_head
      assign a_src = row_a;
      assign b_src = row_b;
      assign c_src = cin0;
      assign ld    = in_valid & in_ready;
      assign r_d   = seg[W-1:0];
    end else begin : g_body
      assign a_src = g_st[k-1].g_rem.a_q;
      assign b_src = g_st[k-1].g_rem.b_q;
      assign c_src = g_st[k-1].c_q;
      assign ld    = adv[k-1];
      assign r_d   = {seg[W-1:0], g_st[k-1].r_q};
    end

    assign seg  = {1'b0, a_src[W-1:0]} + {1'b0, b_src[W-1:0]}
                + {{W{1'b0}}, c_src};
    assign v[k] = v_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else begin
        if (ld) begin
          v_q <= 1'b1;
          c_q <= seg[W];
          r_q <= r_d;
        end else if (adv[k]) begin
          v_q <= 1'b0;
        end
      end
    end

    // Operand bits not yet added travel on with the stage.
    if (RW > W) begin : g_rem
      logic [RW-W-1:0] a_q;
      logic [RW-W-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ld) begin
          a_q <= a_src[RW-1:W];
          b_q <= b_src[RW-1:W];
        end
      end
    end
  end

  assign sum = {g_st[NSTG-1].c_q, g_st[NSTG-1].r_q};

endmodule

// File: tb/tb_cpa_pipe.sv
// Bench for cpa_pipe: queue-based reference model, handshake and stall checks.
// Covers the optional CPA_PIPE_CIN_EN carry-in when defined.
module tb_cpa_pipe;

`ifdef CPA_PIPE_CIN_EN
  localparam bit HAS_CIN = 1'b1;
`else
  localparam bit HAS_CIN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] row_a = '0;
  logic [31:0] row_b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [32:0] sum;
  logic        busy;

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [19:0] row_a2 = '0;
  logic [19:0] row_b2 = '0;
  logic        cin2 = 1'b0;
  logic        out_valid2;
  logic        out_ready2 = 1'b1;
  logic [20:0] sum2;
  logic        busy2;

  always #5 clk = ~clk;

  cpa_pipe #(.WIDTH(32), .SEG(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef CPA_PIPE_CIN_EN
    .cin       (cin),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .row_a     (row_a),
    .row_b     (row_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .busy      (busy)
  );

  cpa_pipe #(.WIDTH(20), .SEG(8)) u_dut20 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef CPA_PIPE_CIN_EN
    .cin       (cin2),
`endif
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .row_a     (row_a2),
    .row_b     (row_b2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .sum       (sum2),
    .busy      (busy2)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [63:0] sb[$];
  int          acc_n = 0;
  int          drn_n = 0;
  int          cyc_n = 0;
  int          first_drn = 0;
  int          last_drn = 0;
  logic [63:0] last_sum = '0;

  // One clock: evaluate the handshakes that the coming edge will perform.
  task automatic cyc();
    logic [63:0] e;
    #1;
    if (in_valid && in_ready) begin
      sb.push_back(64'(row_a) + 64'(row_b) + 64'(HAS_CIN & cin));
      acc_n++;
    end
    if (out_valid && out_ready) begin
      e = (sb.size() != 0) ? sb.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
      chk("sum_model", 64'(sum), e);
      last_sum = 64'(sum);
      if (drn_n == 0) first_drn = cyc_n;
      last_drn = cyc_n;
      drn_n++;
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic clr();
    acc_n = 0;
    drn_n = 0;
    sb.delete();
  endtask

  task automatic one_op(input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic [63:0] want,
                        input string tag);
    int a0, d0, t0, n;
    row_a = a;
    row_b = b;
    cin = c;
    in_valid = 1'b1;
    a0 = acc_n;
    d0 = drn_n;
    t0 = cyc_n;
    cyc();
    in_valid = 1'b0;
    chk({tag, "_acc"}, 64'(acc_n - a0), 64'd1);
    n = 0;
    while (drn_n == d0 && n < 20) begin
      cyc();
      n++;
    end
    chk({tag, "_lat"}, 64'(last_drn - t0), 64'd4);
    chk({tag, "_sum"}, last_sum, want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, stalls, moved, a_prev;
    logic [32:0] held;
    bit          have;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ovalid", 64'(out_valid), 64'd0);
    chk("rst_busy",   64'(busy),      64'd0);
    chk("rst_sum",    64'(sum),       64'd0);
    chk("rst_sum20",  64'(sum2),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_irdy", 64'(in_ready), 64'd1);
    @(negedge clk);

    clr();
    one_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 64'h100, "t1");
    one_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 64'h1_0000_0000, "t2");
    one_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'h1_FFFF_FFFE, "t2ones");
    if (HAS_CIN) begin
      one_op(32'hFFFF_FFFF, 32'h0, 1'b1, 64'h1_0000_0000, "t2cin");
      one_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h1_FFFF_FFFF, "t2cin1s");
    end

    clr();
    stalls = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      row_a = $urandom;
      row_b = $urandom;
      cin = 1'($urandom_range(0, 1));
      a_prev = acc_n;
      cyc();
      if (acc_n == a_prev) stalls++;
    end
    in_valid = 1'b0;
    n = 0;
    while (drn_n < 100 && n < 30) begin
      cyc();
      n++;
    end
    chk("t3_stall", 64'(stalls), 64'd0);
    chk("t3_cnt",   64'(drn_n),  64'd100);
    chk("t3_tput",  64'(last_drn - first_drn), 64'd99);
    chk("t3_empty", 64'(sb.size()), 64'd0);

    clr();
    out_ready = 1'b0;
    in_valid = 1'b1;
    moved = 0;
    have = 1'b0;
    held = '0;
    for (int i = 0; i < 10; i++) begin
      a_prev = acc_n;
      cyc();
      if (out_valid) begin
        if (!have) held = sum;
        else if (sum !== held) moved++;
        have = 1'b1;
      end
      if (acc_n != a_prev) begin
        row_a = $urandom;
        row_b = $urandom;
        cin = 1'($urandom_range(0, 1));
      end
    end
    chk("t4_acc",    64'(acc_n), 64'd4);
    chk("t4_stable", 64'(moved), 64'd0);
    chk("t4_ovalid", 64'(out_valid), 64'd1);
    #1;
    chk("t4_irdy", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    cyc();
    chk("t4_both_acc", 64'(acc_n), 64'd5);
    chk("t4_both_drn", 64'(drn_n), 64'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) cyc();
    chk("t4_drn",   64'(drn_n), 64'd5);
    chk("t4_empty", 64'(sb.size()), 64'd0);
    chk("t4_busy",  64'(busy), 64'd0);

    clr();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      row_a = $urandom;
      row_b = $urandom;
      cyc();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_ovalid", 64'(out_valid), 64'd0);
    chk("t5_busy",   64'(busy),      64'd0);
    chk("t5_sum",    64'(sum),       64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    @(negedge clk);
    one_op(32'h1234_5678, 32'h8765_4321, 1'b0, 64'h9999_9999, "t5");
    for (int i = 0; i < 6; i++) cyc();
    chk("t5_drn", 64'(drn_n), 64'd1);

    row_a2 = 20'hFFFFF;
    row_b2 = 20'hFFFFF;
    in_valid2 = 1'b1;
    #1;
    chk("t6_irdy", 64'(in_ready2), 64'd1);
    @(negedge clk);
    in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t6_lat", 64'(n + 1), 64'd3);
    chk("t6_sum", 64'(sum2), 64'h1F_FFFE);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
